multi0arb2: RTL and testbench
=============================

# multi0arb2

Two-requester arbiter and sequencer that shares a single `multi0keep` multi-cycle unit. Each requester submits a 32-bit operand over a valid/ready handshake. The block grants requesters in round-robin order, pulses the unit's `start`, and waits for `done`. It then returns the unit's result to the granted requester over a valid/ready response channel. It sits between client logic and one `multi0keep` instance, which is reset by the same `reset`.

## Interface
Parameters:
- `TIMEOUT`, default 64: maximum cycles to wait for `unit_done` (used only with the timeout feature).

Ports:
- `clock`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  requester has an operand.
- `req0_ready` / `req1_ready`  out  1  operand accepted this cycle.
- `req0_data` / `req1_data`  in  32  operand.
- `resp0_valid` / `resp1_valid`  out  1  result available.
- `resp0_ready` / `resp1_ready`  in  1  requester consumes the result.
- `resp_data`  out  32  result, shared by both response channels.
- `resp_err`  out  1  result invalid because of a timeout.
- `unit_start`  out  1  start pulse to the unit.
- `unit_inp`  out  32  operand to the unit.
- `unit_done`  in  1  unit finished.
- `unit_out`  in  32  unit result.

## Operation
- States: IDLE, BUSY, RESP.
- IDLE:
  - `reqN_ready` = state==IDLE && grant==N, computed combinationally from the valids and the priority pointer `ptr`.
  - If only one requester is valid, that requester is granted.
  - If both are valid, requester `ptr` is granted.
  - An accept occurs when `reqN_valid && reqN_ready`.
  - On accept: latch the operand into `unit_inp`, record owner N, set `ptr` to the other requester, and go to BUSY.
- BUSY:
  - `unit_start` is 1 only in the first BUSY cycle.
  - `unit_inp` is held constant for the whole transaction.
  - `unit_done` is ignored in the start cycle.
  - In any later BUSY cycle with `unit_done`=1: latch `unit_out` into `resp_data`, set `resp_err`=0, and go to RESP.
- RESP:
  - `respN_valid`=1 for the owner only; the other response valid stays 0.
  - `resp_data` and `resp_err` are held stable.
  - When `respN_ready`=1: go to IDLE. `respN_valid` drops in the next cycle.
  - The ready of the non-owner is ignored.
- Only one transaction is in flight at a time. No request is accepted outside IDLE.

Reset values (asynchronous):
- state IDLE, `ptr`=0.
- All ready and valid outputs 0, `unit_start`=0.
- `unit_inp`=0, `resp_data`=0, `resp_err`=0.

Reset mid-transaction: the transaction is abandoned with no response. Because the unit is reset by the same signal, there is no stale `done`.

## Timing
- Accept at cycle t, then `unit_start`=1 at t+1.
- `unit_done` is first sampled at t+2.
- If `done` is seen at cycle d, `respN_valid`=1 from d+1.
- A response handshake at cycle h means IDLE at h+1; the next accept can happen at h+1.
- Minimum request-to-request spacing with a unit latency of L cycles (start to done) and an immediate response ready: L+3 cycles.
- `reqN_ready` is combinational from `reqN_valid`. There is no combinational path from `resp*_ready` to any output.

## Configuration
Macro `MULTI0ARB2_TIMEOUT_EN`:
- Defined:
  - A cycle counter runs in BUSY, starting at 0 in the start cycle.
  - If it reaches `TIMEOUT` without `unit_done`, go to RESP with `resp_data`=0 and `resp_err`=1.
  - If `unit_done` arrives in the same cycle the limit is reached, `done` wins.
- Undefined:
  - No counter logic is built.
  - `resp_err` is tied to 0.
  - BUSY waits indefinitely for `done`.

## Test plan
- Single request: reset, `req0_data`=0x0000_0005, valid held, unit model with L=3 -> `req0_ready` at t, `unit_start` at t+1 with `unit_inp`=5, `resp0_valid` at t+5 carrying the model's result, `resp1_valid` stays 0.
- Simultaneous requests after reset: both valid, `req1_data`=0xA -> req0 served first; req1 is accepted at the cycle after req0's response handshake, and its response carries the result for 0xA.
- Fairness: both requesters valid continuously for 6 transactions -> grants alternate 0,1,0,1,0,1.
- Backpressure: `resp0_ready`=0 for 10 cycles after `resp0_valid` -> `resp_data` stable, `req1_ready`=0 throughout, IDLE one cycle after `ready` rises.
- Reset mid-BUSY: assert `reset` 2 cycles after `unit_start` -> all outputs 0 immediately, no response, and a new request afterwards completes normally.
- Timeout (macro defined, `TIMEOUT`=8): unit never asserts `done` -> `resp0_valid` with `resp_err`=1 and `resp_data`=0, 9 cycles after the start cycle. With the macro undefined, no response is produced within 100 cycles.

Source files
------------

// File: rtl/multi0arb2.sv
// rtl/multi0arb2.sv - round-robin two-requester sequencer for one multi0keep unit (option: MULTI0ARB2_TIMEOUT_EN)
module multi0arb2 #(
    parameter int TIMEOUT = 64
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req0_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [31:0] req1_data,
    output logic        resp0_valid,
    input  logic        resp0_ready,
    output logic        resp1_valid,
    input  logic        resp1_ready,
    output logic [31:0] resp_data,
    output logic        resp_err,
    output logic        unit_start,
    output logic [31:0] unit_inp,
    input  logic        unit_done,
    input  logic [31:0] unit_out
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

    state_t state;
    logic   ptr;
    logic   owner;
    logic   grant;
    logic   accept;
    logic   resp_fire;

    generate
        if (TIMEOUT < 1) begin : g_bad_timeout
            $error("multi0arb2: TIMEOUT must be at least 1");
        end
    endgenerate

    // The pointer only breaks ties; a lone valid requester always wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid)
            grant = ptr;
        else if (req1_valid)
            grant = 1'b1;
    end

    assign req0_ready = (state == IDLE) && req0_valid && !grant;
    assign req1_ready = (state == IDLE) && req1_valid && grant;
    assign accept     = req0_ready || req1_ready;
    assign resp_fire  = owner ? resp1_ready : resp0_ready;

`ifdef MULTI0ARB2_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] cnt;
`else
    assign resp_err = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            ptr         <= 1'b0;
            owner       <= 1'b0;
            unit_start  <= 1'b0;
            unit_inp    <= '0;
            resp_data   <= '0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
`ifdef MULTI0ARB2_TIMEOUT_EN
            resp_err    <= 1'b0;
            cnt         <= '0;
`endif
        end else begin
            unit_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        unit_inp   <= grant ? req1_data : req0_data;
                        owner      <= grant;
                        ptr        <= !grant;
                        unit_start <= 1'b1;
                        state      <= BUSY;
`ifdef MULTI0ARB2_TIMEOUT_EN
                        cnt        <= '0;
`endif
                    end
                end
                BUSY: begin
`ifdef MULTI0ARB2_TIMEOUT_EN
                    cnt <= cnt + 1'b1;
`endif
                    // unit_start is high exactly in the start cycle, where done is ignored.
                    if (!unit_start && unit_done) begin
                        resp_data   <= unit_out;
                        resp0_valid <= !owner;
                        resp1_valid <= owner;
                        state       <= RESP;
`ifdef MULTI0ARB2_TIMEOUT_EN
                        resp_err    <= 1'b0;
                    end else if (cnt == CW'(TIMEOUT)) begin
                        resp_data   <= '0;
                        resp_err    <= 1'b1;
                        resp0_valid <= !owner;
                        resp1_valid <= owner;
                        state       <= RESP;
`endif
                    end
                end
                RESP: begin
                    if (resp_fire) begin
                        resp0_valid <= 1'b0;
                        resp1_valid <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_multi0arb2.sv
// tb/tb_multi0arb2.sv - scoreboard bench for multi0arb2 with a behavioural unit model
module tb_multi0arb2;

    logic        clock = 1'b0;
    logic        reset;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] req0_data, req1_data;
    logic        resp0_valid, resp1_valid;
    logic        resp0_ready, resp1_ready;
    logic [31:0] resp_data;
    logic        resp_err;
    logic        unit_start;
    logic [31:0] unit_inp;
    logic        unit_done;
    logic [31:0] unit_out;

    always #5 clock = ~clock;

    multi0arb2 #(.TIMEOUT(8)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_data(req0_data),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_data(req1_data),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .unit_start(unit_start), .unit_inp(unit_inp),
        .unit_done(unit_done), .unit_out(unit_out)
    );

    typedef struct packed {
        logic        owner;
        logic [31:0] data;
        logic        err;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] unit_fn(input logic [31:0] x);
        return x * 32'd3 + 32'h0000_1234;
    endfunction

    // Unit model: done pulses L cycles after the start cycle.
    int          lat = 3;
    int          ucnt = 0;
    bit          hang = 0;
    logic [31:0] ulat = '0;
    initial begin
        unit_done = 1'b0;
        unit_out  = '0;
        forever begin
            @(posedge clock);
            #1;
            unit_done = 1'b0;
            if (reset) begin
                ucnt = 0;
            end else begin
                if (ucnt > 0) begin
                    ucnt--;
                    if (ucnt == 0) begin
                        unit_done = 1'b1;
                        unit_out  = unit_fn(ulat);
                    end
                end
                if (unit_start && !hang) begin
                    ucnt = lat;
                    ulat = unit_inp;
                end
            end
        end
    end

    bit rand_rdy = 0;
    bit rr0 = 0, rr1 = 0;
    bit dir0 = 1, dir1 = 1;
    assign resp0_ready = rand_rdy ? rr0 : dir0;
    assign resp1_ready = rand_rdy ? rr1 : dir1;
    initial forever begin
        @(posedge clock);
        #1;
        rr0 = ($urandom % 3) != 0;
        rr1 = ($urandom % 3) != 0;
    end

    // Monitor: pops the scoreboard on every response handshake.
    initial forever begin
        @(negedge clock);
        if (!reset) begin
            if (resp0_valid || resp1_valid)
                check_eq("resp_onehot", {31'b0, resp0_valid & resp1_valid}, 32'd0);
            for (int n = 0; n < 2; n++) begin
                if ((n == 0 && resp0_valid && resp0_ready) || (n == 1 && resp1_valid && resp1_ready)) begin
                    if (exp_q.size() == 0) begin
                        check_eq("unexpected_resp", 32'(n), 32'hFFFF_FFFF);
                    end else begin
                        exp_t e;
                        e = exp_q.pop_front();
                        check_eq("resp_owner", 32'(n), {31'b0, e.owner});
                        check_eq("resp_data", resp_data, e.data);
                        check_eq("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                    end
                end
            end
        end
    end

    logic mptr = 1'b0;

    task automatic reset_dut();
        @(posedge clock);
        #1;
        reset = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        exp_q.delete();
        mptr = 1'b0;
        hang = 0;
    endtask

    task automatic wait_empty(input int budget);
        bit done_ok;
        done_ok = 0;
        for (int c = 0; c < budget; c++) begin
            @(negedge clock);
            if (exp_q.size() == 0) begin
                done_ok = 1;
                break;
            end
        end
        checks++;
        if (!done_ok) begin
            errors++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_resp0();
        bit seen;
        seen = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clock);
            if (resp0_valid) begin
                seen = 1;
                break;
            end
        end
        check_eq("resp0_arrives", {31'b0, seen}, 32'd1);
    endtask

    initial begin
        logic [31:0] held;
        logic [31:0] d0, d1;
        bit v0, v1, found, seen;
        logic w;

        reset = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_data = '0; req1_data = '0;
        @(negedge clock);
        check_eq("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
        check_eq("rst_req1_ready", {31'b0, req1_ready}, 32'd0);
        check_eq("rst_resp_valid", {30'b0, resp1_valid, resp0_valid}, 32'd0);
        check_eq("rst_unit_start", {31'b0, unit_start}, 32'd0);
        check_eq("rst_unit_inp", unit_inp, 32'd0);
        check_eq("rst_resp_data", resp_data, 32'd0);
        check_eq("rst_resp_err", {31'b0, resp_err}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;

        // Single request: latency profile with L=3
        lat = 3;
        @(posedge clock); #1;
        req0_valid = 1'b1; req0_data = 32'd5;
        @(negedge clock);
        check_eq("single_req0_ready", {31'b0, req0_ready}, 32'd1);
        exp_q.push_back('{owner: 1'b0, data: unit_fn(32'd5), err: 1'b0});
        @(posedge clock); #1;
        req0_valid = 1'b0;
        @(negedge clock);
        check_eq("single_unit_start", {31'b0, unit_start}, 32'd1);
        check_eq("single_unit_inp", unit_inp, 32'd5);
        for (int k = 2; k < 5; k++) begin
            @(negedge clock);
            check_eq("single_resp_early", {31'b0, resp0_valid}, 32'd0);
            check_eq("single_start_once", {31'b0, unit_start}, 32'd0);
        end
        @(negedge clock);
        check_eq("single_resp0_t5", {31'b0, resp0_valid}, 32'd1);
        check_eq("single_resp1_low", {31'b0, resp1_valid}, 32'd0);
        wait_empty(10);

        // Simultaneous requests after reset
        reset_dut();
        req0_valid = 1'b1; req0_data = $urandom;
        req1_valid = 1'b1; req1_data = 32'h0000_000A;
        @(negedge clock);
        check_eq("simul_req0_first", {30'b0, req1_ready, req0_ready}, 32'd1);
        exp_q.push_back('{owner: 1'b0, data: unit_fn(req0_data), err: 1'b0});
        @(posedge clock); #1;
        req0_valid = 1'b0;
        wait_resp0();
        @(negedge clock);
        check_eq("simul_req1_after_hs", {31'b0, req1_ready}, 32'd1);
        exp_q.push_back('{owner: 1'b1, data: unit_fn(32'h0000_000A), err: 1'b0});
        @(posedge clock); #1;
        req1_valid = 1'b0;
        wait_empty(20);

        // Backpressure on resp0
        @(posedge clock); #1;
        dir0 = 0;
        req0_valid = 1'b1; req0_data = $urandom;
        @(negedge clock);
        check_eq("bp_req0_ready", {31'b0, req0_ready}, 32'd1);
        exp_q.push_back('{owner: 1'b0, data: unit_fn(req0_data), err: 1'b0});
        @(posedge clock); #1;
        req0_valid = 1'b0;
        req1_valid = 1'b1; req1_data = $urandom;
        wait_resp0();
        held = resp_data;
        for (int k = 0; k < 10; k++) begin
            @(negedge clock);
            check_eq("bp_resp_data_stable", resp_data, held);
            check_eq("bp_req1_ready_low", {31'b0, req1_ready}, 32'd0);
            check_eq("bp_resp0_held", {31'b0, resp0_valid}, 32'd1);
        end
        @(posedge clock); #1;
        dir0 = 1;
        @(negedge clock);
        check_eq("bp_req1_ready_hs", {31'b0, req1_ready}, 32'd0);
        @(negedge clock);
        check_eq("bp_idle_next", {31'b0, req1_ready}, 32'd1);
        exp_q.push_back('{owner: 1'b1, data: unit_fn(req1_data), err: 1'b0});
        @(posedge clock); #1;
        req1_valid = 1'b0;
        wait_empty(20);

        // Fairness: both valid continuously; pointer is 0 here
        mptr = 1'b0;
        @(posedge clock); #1;
        req0_valid = 1'b1; req0_data = $urandom;
        req1_valid = 1'b1; req1_data = $urandom;
        for (int t = 0; t < 6; t++) begin
            found = 0;
            for (int c = 0; c < 50; c++) begin
                @(negedge clock);
                if (req0_ready || req1_ready) begin
                    found = 1;
                    break;
                end
            end
            check_eq("fair_grant", {30'b0, req1_ready, req0_ready}, (t % 2 == 0) ? 32'd1 : 32'd2);
            if (!found) break;
            exp_q.push_back('{owner: req1_ready, data: unit_fn(req1_ready ? req1_data : req0_data), err: 1'b0});
            @(posedge clock); #1;
            if (t % 2 == 0) req0_data = $urandom;
            else            req1_data = $urandom;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_empty(30);

        // Reset two cycles after the start cycle
        lat = 5;
        @(posedge clock); #1;
        req0_valid = 1'b1; req0_data = 32'h0000_0077;
        @(negedge clock);
        check_eq("mid_accept", {31'b0, req0_ready}, 32'd1);
        @(posedge clock); #1;
        req0_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        exp_q.delete();
        #1;
        check_eq("mid_rst_valids", {28'b0, req1_ready, req0_ready, resp1_valid, resp0_valid}, 32'd0);
        check_eq("mid_rst_unit_start", {31'b0, unit_start}, 32'd0);
        check_eq("mid_rst_unit_inp", unit_inp, 32'd0);
        check_eq("mid_rst_resp_data", resp_data, 32'd0);
        check_eq("mid_rst_resp_err", {31'b0, resp_err}, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        lat = 2;
        req1_valid = 1'b1; req1_data = 32'h0000_0123;
        @(negedge clock);
        check_eq("post_rst_accept", {31'b0, req1_ready}, 32'd1);
        exp_q.push_back('{owner: 1'b1, data: unit_fn(32'h0000_0123), err: 1'b0});
        @(posedge clock); #1;
        req1_valid = 1'b0;
        wait_empty(20);

        // Unit never finishes
        hang = 1;
        @(posedge clock); #1;
        req0_valid = 1'b1; req0_data = 32'h0000_0042;
        @(negedge clock);
        check_eq("to_accept", {31'b0, req0_ready}, 32'd1);
`ifdef MULTI0ARB2_TIMEOUT_EN
        exp_q.push_back('{owner: 1'b0, data: 32'd0, err: 1'b1});
        @(posedge clock); #1;
        req0_valid = 1'b0;
        for (int k = 1; k < 10; k++) begin
            @(negedge clock);
            check_eq("to_resp_early", {31'b0, resp0_valid}, 32'd0);
        end
        @(negedge clock);
        check_eq("to_resp0_valid", {31'b0, resp0_valid}, 32'd1);
        check_eq("to_resp_err", {31'b0, resp_err}, 32'd1);
        check_eq("to_resp_data", resp_data, 32'd0);
        wait_empty(10);
        hang = 0;
`else
        @(posedge clock); #1;
        req0_valid = 1'b0;
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clock);
            if (resp0_valid || resp1_valid) seen = 1;
        end
        check_eq("no_timeout_resp", {31'b0, seen}, 32'd0);
`endif

        // Randomized traffic against the arbitration rules
        reset_dut();
        rand_rdy = 1;
        v0 = 0; v1 = 0; d0 = '0; d1 = '0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clock); #1;
            if (!v0 && ($urandom % 2 == 1)) begin v0 = 1; d0 = $urandom; end
            if (!v1 && ($urandom % 2 == 1)) begin v1 = 1; d1 = $urandom; end
            if (!v0 && !v1) begin v0 = 1; d0 = $urandom; end
            lat = $urandom_range(1, 4);
            req0_valid = v0; req0_data = d0;
            req1_valid = v1; req1_data = d1;
            found = 0;
            for (int c = 0; c < 200; c++) begin
                @(negedge clock);
                if (req0_ready || req1_ready) begin
                    found = 1;
                    break;
                end
            end
            if (!found) begin
                check_eq("rand_no_accept", 32'd0, 32'd1);
                break;
            end
            w = (v0 && v1) ? mptr : v1;
            check_eq("rand_grant", {30'b0, req1_ready, req0_ready}, w ? 32'd2 : 32'd1);
            exp_q.push_back('{owner: w, data: unit_fn(w ? d1 : d0), err: 1'b0});
            mptr = !w;
            if (w) v1 = 0;
            else   v0 = 0;
            @(posedge clock); #1;
            req0_valid = v0;
            req1_valid = v1;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        wait_empty(400);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish, errors=%0d", errors);
        $fatal(1, "global timeout");
    end

endmodule
